axi_slave_mem: RTL and testbench
================================

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, SHALL set the number of 32-bit memory words; it is a power of two, 4..1024.
REQ-002 aclk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 areset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 awid  input  4  write address ID.
REQ-005 awadr  input  32  write start address.
REQ-006 awlen  input  4  write beats minus one.
REQ-007 awsize  input  3  write beat size.
REQ-008 awburst  input  2  write burst type, 00 FIXED / 01 INCR.
REQ-009 awvalid  input  1; awready  output  1  write address handshake.
REQ-010 wid  input  4  write data ID.
REQ-011 wrdata  input  32  write data.
REQ-012 wstrb  input  4  byte strobes.
REQ-013 wlast  input  1  last write beat.
REQ-014 wvalid  input  1; wready  output  1  write data handshake.
REQ-015 bid  output  4; bresp  output  2  write response ID and code.
REQ-016 bvalid  output  1; bready  input  1  write response handshake.
REQ-017 arid  input  4; araddr  input  32; arlen  input  4; arsize  input  3  read address channel.
REQ-018 arvalid  input  1; arready  output  1  read address handshake.
REQ-019 rid  output  4; rdata  output  32; rresp  output  2; rlast  output  1  read data channel.
REQ-020 rvalid  output  1; rready  input  1  read data handshake.
REQ-021 Lock, cache and protection signals SHALL NOT be ports; the block does not depend on them.

Function
REQ-022 FSM SHALL have states IDLE, WDATA, WRESP, RDATA; only one transaction is in flight at a time.
REQ-023 In IDLE: awready = 1; arready = !awvalid. Simultaneous awvalid and arvalid: write SHALL win and the read waits.
REQ-024 On AW handshake, SHALL latch awid, awadr, awlen, awburst, clear beat count and error flag, and go to WDATA the next cycle.
REQ-025 In WDATA: wready = 1. On each W handshake, SHALL write only the bytes whose wstrb bit is set into word addr[log2(DEPTH_WORDS)+1:2].
REQ-026 Address SHALL advance by 4 per beat for INCR and stay fixed for FIXED, regardless of awsize; arithmetic is modulo 2^32.
REQ-027 A beat SHALL be out of range when addr >= 4*DEPTH_WORDS; the write is dropped and the error flag is set.
REQ-028 The error flag SHALL also be set when wid != latched ID, or when wlast != (beat count == awlen).
REQ-029 On the beat where count == awlen, SHALL go to WRESP with bvalid = 1, bid = latched ID, and bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00; wlast is not used to terminate the burst.
REQ-030 In WRESP, outputs SHALL hold until bready is sampled high, then return to IDLE (bvalid low the next cycle).
REQ-031 On AR handshake, SHALL latch arid, araddr, arlen; reads are always INCR. Next cycle: RDATA with rvalid = 1 and rdata = mem[word].
REQ-032 rvalid, rdata, rresp, rid and rlast (= count == arlen) SHALL hold stable until rready; on each handshake that is not last, the next beat SHALL be presented the following cycle.
REQ-033 An out-of-range read beat SHALL return rdata = 0 and rresp = 2'b10; otherwise rresp = 2'b00.
REQ-034 After the last R handshake, SHALL return to IDLE, so rvalid is low for at least one cycle between read bursts.
REQ-035 Read data SHALL reflect all writes completed before the AR handshake.

Reset
REQ-036 While areset is high, SHALL enter IDLE; awready, wready, bvalid, arready, rvalid and rlast = 0; bid, bresp, rid, rresp and rdata = 0. awready and arready return per REQ-023 the first cycle after release.
REQ-037 Reset mid-transaction SHALL abandon it with no response; memory contents SHALL NOT be reset or cleared.

Verification
REQ-038 Single write 0x10 data 0xDEADBEEF strb 0xF, then read 0x10 -> bresp 00, rdata 0xDEADBEEF, rlast 1, rresp 00.
REQ-039 Write 0x20 0xFFFFFFFF, then write 0x20 0x00000000 strb 0x5 -> read returns 0xFF00FF00.
REQ-040 INCR write awlen 3 at 0x0 data 1,2,3,4; read arlen 3 at 0x0 -> four beats 1,2,3,4, rlast only on beat 4, rready toggled to check stall holding.
REQ-041 Write to 0x100 with DEPTH_WORDS 64 -> bresp 10, memory unchanged; read 0x100 -> rdata 0, rresp 10.
REQ-042 awvalid and arvalid asserted in the same cycle -> write completes first, then the read returns the new data.
REQ-043 areset asserted during the WDATA beat 2 of 4 -> no bvalid; the following read shows beats 1-2 written and beats 3-4 unchanged.

Source files
------------

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3-style slave backed by a DEPTH_WORDS x 32-bit memory.
//
// Purpose:
//   Accepts one transaction at a time: either a write burst (AW, W beats, B)
//   or a read burst (AR, R beats). Writes honour byte strobes. Out-of-range
//   beats are dropped or read back as zero, and they are answered with SLVERR.
//
// Ports:
//   aclk, areset             clock, synchronous active-high reset
//   aw*  / awvalid, awready  write address channel (awsize is accepted but ignored)
//   w*   / wvalid, wready    write data channel
//   bid, bresp / bvalid, bready  write response channel
//   ar*  / arvalid, arready  read address channel (arsize is ignored; reads are INCR)
//   rid, rdata, rresp, rlast / rvalid, rready  read data channel
//   dbg_state                current FSM state (IDLE=0, WDATA=1, WRESP=2, RDATA=3)
//
// Handshake: a transfer happens on a rising edge where both valid and ready
// are high. The slave keeps every valid and its payload stable until the
// matching ready is seen. Ready outputs are decoded from the state alone,
// except that arready also depends on awvalid so that writes win ties.
module axi_slave_mem #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  awid,
    input  logic [31:0] awadr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wrdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, WRESP = 2'd2, RDATA = 2'd3} state_t;

    state_t state, state_nxt;

    logic [3:0]  w_id, w_len, w_cnt;
    logic [31:0] w_addr;
    logic [1:0]  w_burst;
    logic        w_err;
    logic [3:0]  r_id, r_len, r_cnt;
    logic [31:0] r_addr;

    logic [31:0] mem [DEPTH_WORDS];

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_in_range, r_in_range, w_last_beat, r_last_beat, w_err_nxt;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // In range means every address bit above the word index is zero.
    assign w_in_range  = (w_addr[31:AW+2] == '0);
    assign r_in_range  = (r_addr[31:AW+2] == '0);
    assign w_last_beat = (w_cnt == w_len);
    assign r_last_beat = (r_cnt == r_len);

    // The burst length comes from awlen; a misplaced wlast only flags an error.
    assign w_err_nxt = w_err || !w_in_range || (wid != w_id) || (wlast != w_last_beat);

    assign dbg_state = state;

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_hs)      state_nxt = WDATA;
                else if (ar_hs) state_nxt = RDATA;
            end
            WDATA: if (w_hs && w_last_beat) state_nxt = WRESP;
            WRESP: if (b_hs) state_nxt = IDLE;
            RDATA: if (r_hs && r_last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bid     = 4'd0;
        bresp   = 2'b00;
        rvalid  = 1'b0;
        rid     = 4'd0;
        rdata   = 32'd0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        if (!areset) begin
            case (state)
                IDLE: begin
                    awready = 1'b1;
                    arready = !awvalid;
                end
                WDATA: wready = 1'b1;
                WRESP: begin
                    bvalid = 1'b1;
                    bid    = w_id;
                    bresp  = w_err ? 2'b10 : 2'b00;
                end
                RDATA: begin
                    rvalid = 1'b1;
                    rid    = r_id;
                    rlast  = r_last_beat;
                    rdata  = r_in_range ? mem[r_addr[AW+1:2]] : 32'd0;
                    rresp  = r_in_range ? 2'b00 : 2'b10;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_id    <= 4'd0;
            w_len   <= 4'd0;
            w_cnt   <= 4'd0;
            w_addr  <= 32'd0;
            w_burst <= 2'b00;
            w_err   <= 1'b0;
            r_id    <= 4'd0;
            r_len   <= 4'd0;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
        end else begin
            if (aw_hs) begin
                w_id    <= awid;
                w_len   <= awlen;
                w_cnt   <= 4'd0;
                w_addr  <= awadr;
                w_burst <= awburst;
                w_err   <= 1'b0;
            end
            if (w_hs) begin
                w_err <= w_err_nxt;
                if (!w_last_beat) begin
                    w_cnt <= w_cnt + 4'd1;
                    // Only INCR advances; FIXED (and anything else) stays put.
                    if (w_burst == 2'b01) w_addr <= w_addr + 32'd4;
                end
            end
            if (ar_hs) begin
                r_id   <= arid;
                r_len  <= arlen;
                r_cnt  <= 4'd0;
                r_addr <= araddr;
            end
            if (r_hs && !r_last_beat) begin
                r_cnt  <= r_cnt + 4'd1;
                r_addr <= r_addr + 32'd4;
            end
        end
    end

    // Memory has no reset so contents survive an aborted transaction.
    always_ff @(posedge aclk) begin
        if (!areset && w_hs && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr[AW+1:2]][8*b +: 8] <= wrdata[8*b +: 8];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{awsize, arsize, w_addr[1:0], r_addr[1:0]};

endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;

    localparam int DEPTH = 64;

    logic        aclk, areset;
    logic [3:0]  awid, awlen, wid, wstrb, bid, arid, arlen, rid;
    logic [31:0] awadr, wrdata, araddr, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, bresp, rresp, dbg_state;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_slave_mem #(.DEPTH_WORDS(DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];       // expected rdata per beat
    logic [2:0]  exp_meta_q[$];  // expected {rlast, rresp} per beat
    logic [5:0]  exp_b_q[$];     // expected {bid, bresp}
    logic [31:0] model_mem [DEPTH];
    logic [31:0] wbuf [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [3:0] id, input logic [3:0] strb,
                             input int abort_after, input bit bad_last);
        logic [31:0] a;
        logic        err;
        awid = id; awadr = addr; awlen = len[3:0]; awsize = 3'd2; awburst = burst;
        awvalid = 1'b1;
        #1;
        check("awready", awready, 1);
        tick();
        awvalid = 1'b0;
        a = addr;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wid = id; wrdata = wbuf[i]; wstrb = strb;
            wlast = bad_last ? 1'b0 : (i == len);
            wvalid = 1'b1;
            #1;
            check("wready", wready, 1);
            tick();
            wvalid = 1'b0;
            wlast = 1'b0;
            if (a < 32'(4 * DEPTH)) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_mem[a[7:2]][8*b +: 8] = wbuf[i][8*b +: 8];
            end else begin
                err = 1'b1;
            end
            if (bad_last && i == len) err = 1'b1;
            if (burst == 2'b01) a = a + 32'd4;
            if (abort_after == i + 1) begin
                areset = 1'b1;
                #1;
                check("rst_bvalid", bvalid, 0);
                check("rst_wready", wready, 0);
                check("rst_awready", awready, 0);
                tick();
                areset = 1'b0;
                #1;
                check("post_rst_bvalid", bvalid, 0);
                check("post_rst_awready", awready, 1);
                check("post_rst_state", dbg_state, 0);
                return;
            end
        end
        exp_b_q.push_back({id, err ? 2'b10 : 2'b00});
        bready = 1'b0;
        #1;
        check("bvalid", bvalid, 1);
        tick();
        check("bvalid_hold", bvalid, 1);
        bready = 1'b1;
        #1;
        check("bid_bresp", {bid, bresp}, exp_b_q.pop_front());
        tick();
        bready = 1'b0;
        #1;
        check("bvalid_low", bvalid, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                            input bit stall);
        logic [31:0] a;
        int k;
        arid = id; araddr = addr; arlen = len[3:0]; arsize = 3'd2;
        arvalid = 1'b1;
        #1;
        check("arready", arready, 1);
        for (int i = 0; i <= len; i++) begin
            a = addr + 32'(4 * i);
            if (a < 32'(4 * DEPTH)) begin
                exp_q.push_back(model_mem[a[7:2]]);
                exp_meta_q.push_back({i == len, 2'b00});
            end else begin
                exp_q.push_back(32'd0);
                exp_meta_q.push_back({i == len, 2'b10});
            end
        end
        tick();
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            #1;
            check("rvalid", rvalid, 1);
            if (stall) begin
                k = $urandom_range(1, 3);
                for (int s = 0; s < k; s++) begin
                    check("rdata_hold", rdata, exp_q[0]);
                    check("rmeta_hold", {rlast, rresp}, exp_meta_q[0]);
                    tick();
                end
            end
            rready = 1'b1;
            #1;
            check("rdata", rdata, exp_q.pop_front());
            check("rlast_rresp", {rlast, rresp}, exp_meta_q.pop_front());
            check("rid", rid, id);
            tick();
            rready = 1'b0;
        end
        #1;
        check("rvalid_gap", rvalid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        areset = 1'b1;
        awid = 0; awadr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wrdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arvalid = 0; rready = 0;
        repeat (3) tick();
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rdata", rdata, 0);
        areset = 1'b0;
        #1;
        check("idle_awready", awready, 1);
        check("idle_arready", arready, 1);

        // Prefill words 0..15 so later reads have known contents.
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h5A000000 + 32'(i);
        axi_write(32'h0, 15, 2'b01, 4'h1, 4'hF, 0, 0);

        // Single word write and read back.
        wbuf[0] = 32'hDEADBEEF;
        axi_write(32'h10, 0, 2'b01, 4'h2, 4'hF, 0, 0);
        axi_read(32'h10, 0, 4'h3, 0);

        // Strobed partial overwrite.
        wbuf[0] = 32'hFFFFFFFF;
        axi_write(32'h20, 0, 2'b01, 4'h4, 4'hF, 0, 0);
        wbuf[0] = 32'h00000000;
        axi_write(32'h20, 0, 2'b01, 4'h5, 4'h5, 0, 0);
        axi_read(32'h20, 0, 4'h6, 1);
        check("strb_model", model_mem[8], 32'hFF00FF00);

        // INCR burst of four, read back with stalls.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        axi_write(32'h0, 3, 2'b01, 4'h7, 4'hF, 0, 0);
        axi_read(32'h0, 3, 4'h8, 1);

        // Out-of-range write and read; word 0 must not be aliased.
        wbuf[0] = 32'hBAADF00D;
        axi_write(32'h100, 0, 2'b01, 4'h9, 4'hF, 0, 0);
        axi_read(32'h100, 0, 4'hA, 0);
        axi_read(32'h0, 0, 4'hA, 0);

        // FIXED burst: all beats land on one word.
        wbuf[0] = 32'h7; wbuf[1] = 32'h8; wbuf[2] = 32'h9;
        axi_write(32'h8, 2, 2'b00, 4'hB, 4'hF, 0, 0);
        axi_read(32'h0, 3, 4'hB, 0);

        // Missing wlast: data written, SLVERR returned.
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
        axi_write(32'h30, 1, 2'b01, 4'hC, 4'hF, 0, 1);
        axi_read(32'h30, 1, 4'hC, 0);

        // Burst crossing the top of memory.
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
        axi_write(32'hFC, 1, 2'b01, 4'hD, 4'hF, 0, 0);
        axi_read(32'hFC, 1, 4'hD, 1);

        // Simultaneous AW and AR: write wins, read sees new data.
        arid = 4'hE; araddr = 32'h50; arlen = 4'd0; arsize = 3'd2; arvalid = 1'b1;
        awvalid = 1'b1;
        #1;
        check("tie_arready", arready, 0);
        check("tie_awready", awready, 1);
        wbuf[0] = 32'h12345678;
        axi_write(32'h50, 0, 2'b01, 4'hE, 4'hF, 0, 0);
        axi_read(32'h50, 0, 4'hE, 0);

        // Reset during a burst: beats 1-2 land, 3-4 keep old data.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        axi_write(32'h40, 3, 2'b01, 4'h1, 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
        axi_write(32'h40, 3, 2'b01, 4'h2, 4'hF, 2, 0);
        axi_read(32'h40, 3, 4'h3, 0);
        check("abort_model", model_mem[18], 32'hA2);

        // Randomised strobed bursts inside the prefilled region.
        for (int t = 0; t < 8; t++) begin
            int w, l;
            logic [3:0] s;
            w = $urandom_range(0, 12);
            l = $urandom_range(0, 3);
            s = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
            axi_write(32'(4 * w), l, 2'b01, 4'($urandom_range(0, 15)), s, 0, 0);
            axi_read(32'(4 * w), l, 4'($urandom_range(0, 15)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
